// File: rtl/mem_responder_if.sv
// Processor-to-memory bus: command/address/store data in, grant tag and
// tagged load responses out.
interface mem_responder_if;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_transaction_tag;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_data_tag;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency tagged memory model: LOADs snapshot their block at acceptance
// and respond MEM_LATENCY cycles later; STOREs write immediately.
module mem_responder #(
  parameter int MEM_LATENCY = 20,
  parameter int MEM_DEPTH   = 256
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);
  localparam int         IDX_W     = $clog2(MEM_DEPTH);
  localparam int         NTAG      = 15;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  logic [63:0]      r_mem  [MEM_DEPTH];
  logic [63:0]      r_snap [NTAG];
  logic [4:0]       r_cnt  [NTAG];
  logic [NTAG-1:0]  r_busy;

  logic [IDX_W-1:0] w_idx;
  logic             w_load;
  logic             w_store;
  logic             w_any_free;
  logic             w_accept;
  logic             w_rsp_vld;
  logic [3:0]       w_grant_idx;
  logic [3:0]       w_rsp_idx;
  logic             w_unused_addr;

  // Offset bits and bits above the index are dropped, so addresses wrap.
  assign w_idx         = bus.proc2mem_addr[3+IDX_W-1:3];
  assign w_unused_addr = ^{bus.proc2mem_addr[31:3+IDX_W], bus.proc2mem_addr[2:0]};
  assign w_load        = (bus.proc2mem_command == CMD_LOAD);
  assign w_store       = (bus.proc2mem_command == CMD_STORE);

  always_comb begin
    w_any_free  = 1'b0;
    w_grant_idx = '0;
    for (int i = NTAG - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_any_free  = 1'b1;
        w_grant_idx = 4'(i);
      end
    end
  end

  // Fixed latency plus one acceptance per cycle means at most one slot matures.
  always_comb begin
    w_rsp_vld = 1'b0;
    w_rsp_idx = '0;
    for (int i = NTAG - 1; i >= 0; i--) begin
      if (r_busy[i] && (r_cnt[i] == 5'd0)) begin
        w_rsp_vld = 1'b1;
        w_rsp_idx = 4'(i);
      end
    end
  end

  assign w_accept = w_load && w_any_free && !rst;

  assign bus.mem2proc_transaction_tag = w_accept  ? (w_grant_idx + 4'd1) : 4'd0;
  assign bus.mem2proc_data_tag        = w_rsp_vld ? (w_rsp_idx + 4'd1)   : 4'd0;
  assign bus.mem2proc_data            = w_rsp_vld ? r_snap[w_rsp_idx]    : 64'd0;

  // A responding slot frees on the edge that ends its response cycle, so its
  // tag is not visible as free until the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      for (int i = 0; i < NTAG; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NTAG; i++) begin
        if (w_accept && (w_grant_idx == 4'(i))) begin
          r_busy[i] <= 1'b1;
          r_cnt[i]  <= 5'(MEM_LATENCY - 1);
        end else if (r_busy[i]) begin
          if (r_cnt[i] == 5'd0) r_busy[i] <= 1'b0;
          else                  r_cnt[i]  <= r_cnt[i] - 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) r_mem[w_idx] <= bus.proc2mem_data;
    for (int i = 0; i < NTAG; i++) begin
      if (w_accept && (w_grant_idx == 4'(i))) r_snap[i] <= r_mem[w_idx];
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a latency-20 instance for the main
// traffic and a latency-1 instance for back-to-back tag recycling.
module tb_mem_responder;
  localparam int LAT = 20;

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  exp_t        sb[$];
  logic [63:0] mdl_mem [256];
  int          free_at [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder_if bus();
  mem_responder_if bus1();

  mem_responder #(.MEM_LATENCY(LAT), .MEM_DEPTH(256)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  mem_responder #(.MEM_LATENCY(1), .MEM_DEPTH(256)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One bus cycle on the latency-20 instance; the model predicts the grant.
  task automatic do_cyc(input logic [1:0] cmd, input logic [31:0] addr,
                        input logic [63:0] wdata, input string nm);
    logic [3:0] exp_tag;
    logic [7:0] idx;
    bus.proc2mem_command = cmd;
    bus.proc2mem_addr    = addr;
    bus.proc2mem_data    = wdata;
    idx = addr[10:3];
    @(negedge clk);
    exp_tag = 4'd0;
    if (cmd == 2'd1) begin
      for (int t = 1; t <= 15; t++) begin
        if (free_at[t] <= cyc) begin
          exp_tag = 4'(t);
          break;
        end
      end
    end
    chk({nm, "_tag"}, {60'd0, bus.mem2proc_transaction_tag}, {60'd0, exp_tag});
    if (exp_tag != 4'd0) begin
      free_at[exp_tag] = cyc + LAT + 1;
      sb.push_back('{exp_tag, mdl_mem[idx], cyc + LAT});
    end
    if (cmd == 2'd2) mdl_mem[idx] = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_cyc(2'd0, 32'd0, 64'd0, "idle");
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.mem2proc_data_tag != 4'd0) begin
        if (sb.size() == 0) begin
          chk("rsp_unexp", {60'd0, bus.mem2proc_data_tag}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_tag", {60'd0, bus.mem2proc_data_tag}, {60'd0, e.tag});
          chk("rsp_data", bus.mem2proc_data, e.data);
          chk("rsp_cyc", 64'(cyc), 64'(e.cyc));
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        chk("rsp_miss", 64'd0, {60'd0, e.tag});
      end else begin
        chk("data_idle", bus.mem2proc_data, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int t = 0; t < 16; t++) free_at[t] = 0;
    rst = 1'b1;
    bus.proc2mem_command  = 2'd1;
    bus.proc2mem_addr     = 32'd0;
    bus.proc2mem_data     = 64'd0;
    bus1.proc2mem_command = 2'd1;
    bus1.proc2mem_addr    = 32'd0;
    bus1.proc2mem_data    = 64'd0;
    @(negedge clk);
    chk("rst_ttag",  {60'd0, bus.mem2proc_transaction_tag}, 64'd0);
    chk("rst_dtag",  {60'd0, bus.mem2proc_data_tag}, 64'd0);
    chk("rst_data",  bus.mem2proc_data, 64'd0);
    chk("rst1_ttag", {60'd0, bus1.mem2proc_transaction_tag}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus1.proc2mem_command = 2'd0;

    for (int i = 0; i < 33; i++)
      do_cyc(2'd2, 32'(i * 8), 64'hC0DE_0000_0000_0000 | 64'(i), "init");

    // Store then load, fixed latency
    do_cyc(2'd2, 32'h40, 64'hDEADBEEF_00000001, "st40");
    do_cyc(2'd1, 32'h40, 64'd0, "ld40");
    idle(LAT + 2);

    // Exhaust all tags, then retry across the first release
    for (int i = 0; i < 16; i++) do_cyc(2'd1, 32'(i * 8), 64'd0, "burst");
    for (int i = 0; i < 6; i++)  do_cyc(2'd1, 32'h0, 64'd0, "retry");
    idle(LAT + 8);

    // Pending load keeps its snapshot across a later store
    do_cyc(2'd1, 32'h100, 64'd0, "ld100a");
    do_cyc(2'd2, 32'h100, 64'h5, "st100");
    do_cyc(2'd1, 32'h100, 64'd0, "ld100b");
    idle(LAT + 2);

    // Address wrap and ignored byte offset
    do_cyc(2'd2, 32'h800, 64'hA5, "st800");
    do_cyc(2'd1, 32'h000, 64'd0, "ld000");
    do_cyc(2'd1, 32'h003, 64'd0, "ld003");
    idle(LAT + 2);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    // Reset mid-operation discards pending loads
    do_cyc(2'd1, 32'h8, 64'd0, "pre_rst");
    do_cyc(2'd1, 32'h10, 64'd0, "pre_rst");
    do_cyc(2'd1, 32'h18, 64'd0, "pre_rst");
    idle(2);
    rst = 1'b1;
    bus.proc2mem_command = 2'd1;
    @(negedge clk);
    chk("midrst_ttag", {60'd0, bus.mem2proc_transaction_tag}, 64'd0);
    chk("midrst_dtag", {60'd0, bus.mem2proc_data_tag}, 64'd0);
    chk("midrst_data", bus.mem2proc_data, 64'd0);
    sb.delete();
    for (int t = 0; t < 16; t++) free_at[t] = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(LAT + 5);
    do_cyc(2'd1, 32'h8, 64'd0, "post_rst");
    idle(LAT + 2);
    chk("sb_final", 64'(sb.size()), 64'd0);

    // Latency-1 instance: tags alternate 1,2 and respond next cycle
    bus1.proc2mem_command = 2'd2;
    bus1.proc2mem_addr    = 32'h0;
    bus1.proc2mem_data    = 64'h77;
    @(posedge clk);
    #1;
    for (int k = 0; k < 30; k++) begin
      bus1.proc2mem_command = 2'd1;
      bus1.proc2mem_addr    = 32'h0;
      @(negedge clk);
      chk("l1_tag", {60'd0, bus1.mem2proc_transaction_tag}, (k % 2 == 0) ? 64'd1 : 64'd2);
      chk("l1_dtag", {60'd0, bus1.mem2proc_data_tag},
          (k == 0) ? 64'd0 : ((k % 2 == 0) ? 64'd2 : 64'd1));
      if (k > 0) chk("l1_data", bus1.mem2proc_data, 64'h77);
      @(posedge clk);
      #1;
    end
    bus1.proc2mem_command = 2'd0;
    @(negedge clk);
    chk("l1_last_dtag", {60'd0, bus1.mem2proc_data_tag}, 64'd2);
    chk("l1_last_data", bus1.mem2proc_data, 64'h77);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("l1_quiet", {60'd0, bus1.mem2proc_data_tag}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
